// File: rtl/mult_engine.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle after a start pulse.
// Optional MULT_ENGINE_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module mult_engine #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_mcand, w_mcand_nxt;
    logic [PW-1:0]   r_product, w_product_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt, w_mplier_shr;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_busy, r_done;
    logic            w_last;

    // Multiplier after this cycle's shift, and whether this iteration is the final one
    always_comb begin
        w_mplier_shr = {1'b0, r_mplier[WIDTH-1:1]};
`ifdef MULT_ENGINE_EARLY_TERM_EN
        w_last = (w_mplier_shr == {WIDTH{1'b0}});
`else
        w_last = (r_cnt == CW'(WIDTH - 1));
`endif
    end

    // Next-state and datapath update; start is honoured only in IDLE or DONE
    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_product_nxt = r_product;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_BUSY;
                    w_mcand_nxt   = {{WIDTH{1'b0}}, a};
                    w_mplier_nxt  = b;
                    w_product_nxt = {PW{1'b0}};
                    w_cnt_nxt     = {CW{1'b0}};
                end else begin
                    w_state_nxt   = r_state;
                end
            end
            S_BUSY: begin
                if (r_mplier[0]) begin
                    w_product_nxt = r_product + r_mcand;
                end else begin
                    w_product_nxt = r_product;
                end
                w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
                w_mplier_nxt = w_mplier_shr;
                w_cnt_nxt    = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and Moore status flags; rst overrides any pending start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= {PW{1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_product <= {PW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_product <= w_product_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_state_nxt == S_BUSY);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_mult_engine.sv
// Directed scoreboard bench for mult_engine (WIDTH=8); latency expectations follow MULT_ENGINE_EARLY_TERM_EN.
module tb_mult_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  last_b;

    mult_engine #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected number of busy cycles for a given multiplier value
    function automatic int exp_lat(input logic [7:0] bv);
        int l;
`ifdef MULT_ENGINE_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 8; i++) begin
            if (bv[i]) l = i + 1;
        end
`else
        l = 8;
`endif
        return l;
    endfunction

    // Pulse start for one cycle; returns at the negedge after the accepting edge
    task automatic launch(input string tag, input logic [7:0] ta, input logic [7:0] tb_);
        exp_q.push_back(16'(ta) * 16'(tb_));
        last_b = tb_;
        @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        check_eq({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
        check_eq({tag, "_done_on_accept"}, 32'(done), 32'd0);
    endtask

    // Count remaining busy cycles until done, then pop the scoreboard and compare
    task automatic finish_run(input string tag, input int pre);
        int cycles;
        int guard;
        logic [15:0] exp_p;
        cycles = pre;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) cycles++;
            guard++;
            @(negedge clk);
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_lat(last_b)));
        exp_p = exp_q.pop_front();
        check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 8'd0;
        b = 8'd0;
        last_b = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_product", 32'(product), 32'd0);
        rst = 1'b0;

        launch("m13x11", 8'd13, 8'd11);
        finish_run("m13x11", 0);
        repeat (4) @(negedge clk);
        check_eq("hold_done", 32'(done), 32'd1);
        check_eq("hold_product", 32'(product), 32'd143);

        launch("m255x255", 8'd255, 8'd255);
        finish_run("m255x255", 0);

        launch("m0x200", 8'd0, 8'd200);
        finish_run("m0x200", 0);

        // A second start at E3 must be ignored
        launch("m6x7", 8'd6, 8'd7);
        @(negedge clk);
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("m6x7", 3);
        check_eq("ignored_product", 32'(product), 32'd42);

        // Back-to-back start directly from DONE
        launch("m3x5", 8'd3, 8'd5);
        finish_run("m3x5", 0);

        // Reset at E4 of an active run
        launch("abort", 8'd77, 8'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_product", 32'(product), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        check_eq("abort_idle_busy", 32'(busy), 32'd0);
        launch("m21x19", 8'd21, 8'd19);
        finish_run("m21x19", 0);

        launch("m3x1", 8'd3, 8'd1);
        finish_run("m3x1", 0);
        launch("m10x0", 8'd10, 8'd0);
        finish_run("m10x0", 0);
        launch("m2x128", 8'd2, 8'd128);
        finish_run("m2x128", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
